// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD DAT path: state encoding, direction
// encoding and the default counter widths used by the DAT physical layer,
// the buffer wrapper and the transfer sequencer.
package sd_dat_pkg;

    localparam int BLOCK_CNT_WIDTH = 16;
    localparam int TIMEOUT_WIDTH   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUF,
        ST_XFER,
        ST_BLK_GAP,
        ST_DONE,
        ST_ERR
    } xfer_state_e;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } xfer_dir_e;

endpackage

// File: rtl/dat_timeout_cnt.sv
// Per-block data timeout counter. Counts while enabled, clears on request,
// and flags a match when the count equals a non-zero limit. A limit of zero
// disables the match output entirely.
module dat_timeout_cnt #(
    parameter int WIDTH = sd_dat_pkg::TIMEOUT_WIDTH
) (
    input  logic             host_clk,
    input  logic             rst_L,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             match
);

    logic [WIDTH-1:0] cnt;

    // Saturating up-counter; clear has priority over counting.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge host_clk or negedge rst_L) begin
        if (!rst_L) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign match = (limit != '0) && (cnt == limit);

endmodule

// File: rtl/dat_xfer_ctrl.sv
// Host-clock-domain DAT transfer sequencer. Runs single, multi-block and
// open-ended (stop-terminated) transfers, throttles block starts against the
// TX/RX buffers, aborts on a per-block data timeout or a CRC error, and
// reports completion and sticky error status to the host.
module dat_xfer_ctrl #(
    parameter int BLOCK_CNT_WIDTH = sd_dat_pkg::BLOCK_CNT_WIDTH,
    parameter int TIMEOUT_WIDTH   = sd_dat_pkg::TIMEOUT_WIDTH
) (
    input  logic                       host_clk,
    input  logic                       rst_L,
    input  logic                       tx_data_init,
    input  logic                       rx_data_init,
    input  logic                       multi_block,
    input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
    input  logic                       stop_req,
    input  logic [TIMEOUT_WIDTH-1:0]   timeout_val,
    input  logic                       tx_buf_empty,
    input  logic                       rx_buf_full,
    input  logic                       dat_phys_busy,
    input  logic                       blk_done,
    input  logic                       crc_err,
    output logic                       dat_wr_flag,
    output logic                       dat_rd_flag,
    output logic [BLOCK_CNT_WIDTH-1:0] blocks_left,
    output logic                       busy,
    output logic                       xfer_done,
    output logic                       xfer_err,
    output logic                       timeout_err
);

    import sd_dat_pkg::*;

    xfer_state_e              state;
    xfer_dir_e                dir;
    logic                     open_ended;
    logic                     stop_lat;
    logic [TIMEOUT_WIDTH-1:0] tmo_limit;
    logic                     tmo_clr;
    logic                     tmo_en;
    logic                     tmo_match;
    logic                     buf_ready;
    logic                     last_blk;

    // The timeout only runs while waiting for buffer space or moving a block.
    // Holding it clear everywhere else means it is zero on every entry to
    // WAIT_BUF; a good or bad blk_done also restarts it.
    assign tmo_en  = (state == ST_WAIT_BUF) || (state == ST_XFER);
    assign tmo_clr = !tmo_en || ((state == ST_XFER) && blk_done);

    // Write needs a non-empty TX buffer, read needs room in the RX buffer.
    assign buf_ready = (dir == DIR_WRITE) ? !tx_buf_empty : !rx_buf_full;

    // In counted mode the block finishing now is the last one when at most
    // one remains; open-ended transfers only end on a stop.
    assign last_blk = !open_ended && (blocks_left <= BLOCK_CNT_WIDTH'(1));

    dat_timeout_cnt #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_timeout_cnt (
        .host_clk (host_clk),
        .rst_L    (rst_L),
        .clr      (tmo_clr),
        .en       (tmo_en),
        .limit    (tmo_limit),
        .match    (tmo_match)
    );

    // Transfer FSM; every output is a register updated together with the
    // state so the physical layer and host see glitch-free Moore signals.
    always_ff @(posedge host_clk or negedge rst_L) begin
        if (!rst_L) begin
            state       <= ST_IDLE;
            dir         <= DIR_READ;
            open_ended  <= 1'b0;
            stop_lat    <= 1'b0;
            tmo_limit   <= '0;
            dat_wr_flag <= 1'b0;
            dat_rd_flag <= 1'b0;
            blocks_left <= '0;
            busy        <= 1'b0;
            xfer_done   <= 1'b0;
            xfer_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            xfer_done <= 1'b0;

            if (stop_req && (state != ST_IDLE)) begin
                stop_lat <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (tx_data_init || rx_data_init) begin
                        dir         <= tx_data_init ? DIR_WRITE : DIR_READ;
                        open_ended  <= multi_block && (block_cnt == '0);
                        blocks_left <= multi_block ? block_cnt : BLOCK_CNT_WIDTH'(1);
                        tmo_limit   <= timeout_val;
                        xfer_err    <= 1'b0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_WAIT_BUF;
                    end
                end

                ST_WAIT_BUF: begin
                    if (stop_lat) begin
                        xfer_done <= 1'b1;
                        state     <= ST_DONE;
                    end else if (tmo_match) begin
                        xfer_err    <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= ST_ERR;
                    end else if (buf_ready) begin
                        dat_wr_flag <= (dir == DIR_WRITE);
                        dat_rd_flag <= (dir == DIR_READ);
                        state       <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (blk_done) begin
                        dat_wr_flag <= 1'b0;
                        dat_rd_flag <= 1'b0;
                        if (crc_err) begin
                            xfer_err <= 1'b1;
                            state    <= ST_ERR;
                        end else begin
                            if (!open_ended && (blocks_left != '0)) begin
                                blocks_left <= blocks_left - BLOCK_CNT_WIDTH'(1);
                            end
                            if (last_blk || stop_lat || stop_req) begin
                                xfer_done <= 1'b1;
                                state     <= ST_DONE;
                            end else begin
                                state <= ST_BLK_GAP;
                            end
                        end
                    end else if (tmo_match) begin
                        dat_wr_flag <= 1'b0;
                        dat_rd_flag <= 1'b0;
                        xfer_err    <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= ST_ERR;
                    end
                end

                ST_BLK_GAP: begin
                    if (stop_lat) begin
                        xfer_done <= 1'b1;
                        state     <= ST_DONE;
                    end else if (!dat_phys_busy) begin
                        state <= ST_WAIT_BUF;
                    end
                end

                ST_DONE, ST_ERR: begin
                    busy     <= 1'b0;
                    stop_lat <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    busy        <= 1'b0;
                    stop_lat    <= 1'b0;
                    dat_wr_flag <= 1'b0;
                    dat_rd_flag <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dat_xfer_ctrl.sv
// Self-checking bench for dat_xfer_ctrl. Each scenario task drives stimulus
// and checks inline; transfer outcomes are pushed to a scoreboard queue at
// init and popped by a monitor when xfer_done or a new xfer_err appears.
module tb_dat_xfer_ctrl;

    localparam int BW = 16;
    localparam int TW = 16;

    logic          host_clk = 1'b0;
    logic          rst_L = 1'b0;
    logic          tx_data_init = 1'b0;
    logic          rx_data_init = 1'b0;
    logic          multi_block = 1'b0;
    logic [BW-1:0] block_cnt = '0;
    logic          stop_req = 1'b0;
    logic [TW-1:0] timeout_val = '0;
    logic          tx_buf_empty = 1'b0;
    logic          rx_buf_full = 1'b0;
    logic          dat_phys_busy = 1'b0;
    logic          blk_done = 1'b0;
    logic          crc_err = 1'b0;
    logic          dat_wr_flag;
    logic          dat_rd_flag;
    logic [BW-1:0] blocks_left;
    logic          busy;
    logic          xfer_done;
    logic          xfer_err;
    logic          timeout_err;

    typedef struct {
        bit            err;
        bit            tmo;
        logic [BW-1:0] left;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_windows = 0;
    int   rd_windows = 0;
    logic err_q = 1'b0;
    logic wr_q = 1'b0;
    logic rd_q = 1'b0;

    dat_xfer_ctrl #(
        .BLOCK_CNT_WIDTH (BW),
        .TIMEOUT_WIDTH   (TW)
    ) dut (
        .host_clk      (host_clk),
        .rst_L         (rst_L),
        .tx_data_init  (tx_data_init),
        .rx_data_init  (rx_data_init),
        .multi_block   (multi_block),
        .block_cnt     (block_cnt),
        .stop_req      (stop_req),
        .timeout_val   (timeout_val),
        .tx_buf_empty  (tx_buf_empty),
        .rx_buf_full   (rx_buf_full),
        .dat_phys_busy (dat_phys_busy),
        .blk_done      (blk_done),
        .crc_err       (crc_err),
        .dat_wr_flag   (dat_wr_flag),
        .dat_rd_flag   (dat_rd_flag),
        .blocks_left   (blocks_left),
        .busy          (busy),
        .xfer_done     (xfer_done),
        .xfer_err      (xfer_err),
        .timeout_err   (timeout_err)
    );

    always #5 host_clk = ~host_clk;

    // Scoreboard monitor: outcome events are compared on the falling edge.
    always @(negedge host_clk) begin
        exp_t e;
        if (xfer_done || (xfer_err && !err_q)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected done=%0b err=%0b tmo=%0b with nothing expected",
                         xfer_done, xfer_err, timeout_err);
            end else begin
                e = exp_q.pop_front();
                if ({xfer_done, xfer_err, timeout_err} !== {~e.err, e.err, e.tmo} ||
                    blocks_left !== e.left) begin
                    errors++;
                    $display("FAIL sb_outcome got done=%0b err=%0b tmo=%0b left=%0d want done=%0b err=%0b tmo=%0b left=%0d",
                             xfer_done, xfer_err, timeout_err, blocks_left,
                             ~e.err, e.err, e.tmo, e.left);
                end
            end
        end
        if (dat_wr_flag && !wr_q) wr_windows++;
        if (dat_rd_flag && !rd_q) rd_windows++;
        err_q = xfer_err;
        wr_q  = dat_wr_flag;
        rd_q  = dat_rd_flag;
    end

    task automatic tick();
        @(posedge host_clk);
        #1;
    endtask

    task automatic push_exp(input bit err, input bit tmo, input int left);
        exp_t e;
        e.err  = err;
        e.tmo  = tmo;
        e.left = left[BW-1:0];
        exp_q.push_back(e);
    endtask

    task automatic start(input bit wr, input bit rd, input bit multi, input int cnt, input int tmo);
        tx_data_init = wr;
        rx_data_init = rd;
        multi_block  = multi;
        block_cnt    = cnt[BW-1:0];
        timeout_val  = tmo[TW-1:0];
        wr_windows   = 0;
        rd_windows   = 0;
        tick();
        tx_data_init = 1'b0;
        rx_data_init = 1'b0;
    endtask

    // Bounded wait for the selected flag; n is the number of cycles waited.
    task automatic wait_flag(input bit wr, output int n);
        n = 0;
        while (((wr ? dat_wr_flag : dat_rd_flag) !== 1'b1) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL wait_flag_%s got timeout after %0d cycles want flag high",
                     wr ? "wr" : "rd", n);
        end
    endtask

    task automatic finish_block(input int hold, input bit crc);
        repeat (hold) tick();
        blk_done = 1'b1;
        crc_err  = crc;
        tick();
        blk_done = 1'b0;
        crc_err  = 1'b0;
    endtask

    task automatic test_reset();
        rst_L = 1'b0;
        repeat (2) tick();
        checks++;
        if ({dat_wr_flag, dat_rd_flag, busy, xfer_done, xfer_err, timeout_err} !== 6'b0 ||
            blocks_left !== '0) begin
            errors++;
            $display("FAIL reset_outputs got flags=%b left=%0d want 0",
                     {dat_wr_flag, dat_rd_flag, busy, xfer_done, xfer_err, timeout_err}, blocks_left);
        end
        rst_L = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        bit flag_ok = 1'b1;
        tx_buf_empty = 1'b0;
        push_exp(1'b0, 1'b0, 0);
        start(1'b1, 1'b0, 1'b0, 5, 0);
        checks++;
        if (blocks_left !== 16'd1 || dat_wr_flag !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sw_wait_buf got left=%0d wr=%0b busy=%0b want 1 0 1",
                     blocks_left, dat_wr_flag, busy);
        end
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (dat_wr_flag !== 1'b1 || dat_rd_flag !== 1'b0) flag_ok = 1'b0;
        end
        checks++;
        if (!flag_ok) begin
            errors++;
            $display("FAIL sw_flag_window got wr/rd not 1/0 in cycles 2-10 want wr=1 rd=0");
        end
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        checks++;
        if (dat_wr_flag !== 1'b0 || xfer_done !== 1'b1 || blocks_left !== 16'd0) begin
            errors++;
            $display("FAIL sw_complete got wr=%0b done=%0b left=%0d want 0 1 0",
                     dat_wr_flag, xfer_done, blocks_left);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || xfer_done !== 1'b0) begin
            errors++;
            $display("FAIL sw_idle got busy=%0b done=%0b want 0 0", busy, xfer_done);
        end
    endtask

    task automatic test_multi_read();
        int n;
        rx_buf_full = 1'b0;
        push_exp(1'b0, 1'b0, 0);
        start(1'b0, 1'b1, 1'b1, 3, 0);
        for (int b = 0; b < 3; b++) begin
            wait_flag(1'b0, n);
            checks++;
            if (blocks_left !== BW'(3 - b) || dat_wr_flag !== 1'b0) begin
                errors++;
                $display("FAIL mr_block%0d_left got left=%0d wr=%0b want %0d 0",
                         b, blocks_left, dat_wr_flag, 3 - b);
            end
            finish_block(3, 1'b0);
            checks++;
            if (blocks_left !== BW'(2 - b)) begin
                errors++;
                $display("FAIL mr_block%0d_dec got %0d want %0d", b, blocks_left, 2 - b);
            end
            if (b < 2) begin
                rx_buf_full = 1'b1;
                repeat (4) tick();
                rx_buf_full = 1'b0;
                wait_flag(1'b0, n);
                checks++;
                if (n + 4 !== 5) begin
                    errors++;
                    $display("FAIL mr_gap%0d got %0d cycles want 5", b, n + 4);
                end
            end
        end
        tick();
        checks++;
        if (rd_windows !== 3 || wr_windows !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mr_windows got rd=%0d wr=%0d busy=%0b want 3 0 0",
                     rd_windows, wr_windows, busy);
        end
    endtask

    task automatic test_open_ended();
        int n;
        bit left_ok = 1'b1;
        // Stop arrives mid-block 3: that block completes, then DONE.
        push_exp(1'b0, 1'b0, 0);
        start(1'b1, 1'b0, 1'b1, 0, 0);
        for (int b = 0; b < 2; b++) begin
            wait_flag(1'b1, n);
            if (blocks_left !== '0) left_ok = 1'b0;
            finish_block(2, 1'b0);
            if (blocks_left !== '0) left_ok = 1'b0;
        end
        wait_flag(1'b1, n);
        tick();
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        checks++;
        if (dat_wr_flag !== 1'b1) begin
            errors++;
            $display("FAIL oe_stop_midblock got wr=%0b want 1", dat_wr_flag);
        end
        finish_block(2, 1'b0);
        if (blocks_left !== '0) left_ok = 1'b0;
        checks++;
        if (xfer_done !== 1'b1 || wr_windows !== 3) begin
            errors++;
            $display("FAIL oe_three_blocks got done=%0b windows=%0d want 1 3", xfer_done, wr_windows);
        end
        tick();
        // Stop arrives in BLK_GAP while the PHY is busy: DONE without block 3.
        push_exp(1'b0, 1'b0, 0);
        start(1'b1, 1'b0, 1'b1, 0, 0);
        wait_flag(1'b1, n);
        finish_block(2, 1'b0);
        wait_flag(1'b1, n);
        dat_phys_busy = 1'b1;
        finish_block(2, 1'b0);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || xfer_done !== 1'b0) begin
            errors++;
            $display("FAIL oe_gap_hold got busy=%0b done=%0b want 1 0", busy, xfer_done);
        end
        tick();
        if (blocks_left !== '0) left_ok = 1'b0;
        checks++;
        if (xfer_done !== 1'b1 || wr_windows !== 2) begin
            errors++;
            $display("FAIL oe_gap_stop got done=%0b windows=%0d want 1 2", xfer_done, wr_windows);
        end
        dat_phys_busy = 1'b0;
        checks++;
        if (!left_ok) begin
            errors++;
            $display("FAIL oe_left_zero got non-zero blocks_left want 0 throughout");
        end
        tick();
    endtask

    task automatic test_crc_error();
        int n;
        push_exp(1'b1, 1'b0, 3);
        start(1'b1, 1'b0, 1'b1, 4, 0);
        wait_flag(1'b1, n);
        finish_block(2, 1'b0);
        wait_flag(1'b1, n);
        finish_block(2, 1'b1);
        checks++;
        if (dat_wr_flag !== 1'b0 || xfer_err !== 1'b1 || xfer_done !== 1'b0 ||
            timeout_err !== 1'b0 || blocks_left !== 16'd3) begin
            errors++;
            $display("FAIL crc_abort got wr=%0b err=%0b done=%0b tmo=%0b left=%0d want 0 1 0 0 3",
                     dat_wr_flag, xfer_err, xfer_done, timeout_err, blocks_left);
        end
        repeat (3) tick();
        checks++;
        if (xfer_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL crc_sticky got err=%0b busy=%0b want 1 0", xfer_err, busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit early = 1'b0;
        bit quiet = 1'b1;
        push_exp(1'b1, 1'b1, 1);
        start(1'b1, 1'b0, 1'b0, 1, 8);
        checks++;
        if (xfer_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_init_clear got err=%0b want 0", xfer_err);
        end
        wait_flag(1'b1, n);
        for (int k = 0; k < 7; k++) begin
            tick();
            if (xfer_err !== 1'b0 || timeout_err !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early || dat_wr_flag !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early got early=%0b wr=%0b want 0 1", early, dat_wr_flag);
        end
        tick();
        checks++;
        if (xfer_err !== 1'b1 || timeout_err !== 1'b1 || dat_wr_flag !== 1'b0) begin
            errors++;
            $display("FAIL tmo_fire got err=%0b tmo=%0b wr=%0b want 1 1 0",
                     xfer_err, timeout_err, dat_wr_flag);
        end
        tick();
        push_exp(1'b0, 1'b0, 0);
        start(1'b1, 1'b0, 1'b0, 1, 0);
        checks++;
        if (xfer_err !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_reinit_clear got err=%0b tmo=%0b want 0 0", xfer_err, timeout_err);
        end
        wait_flag(1'b1, n);
        repeat (40) begin
            tick();
            if (xfer_err !== 1'b0 || dat_wr_flag !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL tmo_disabled got error or flag drop with timeout_val=0 want none");
        end
        finish_block(1, 1'b0);
        tick();
    endtask

    task automatic test_edge_cases();
        int n;
        tx_buf_empty = 1'b0;
        rx_buf_full  = 1'b0;
        start(1'b1, 1'b1, 1'b1, 2, 0);
        wait_flag(1'b1, n);
        checks++;
        if (dat_rd_flag !== 1'b0 || blocks_left !== 16'd2) begin
            errors++;
            $display("FAIL edge_both_init got rd=%0b left=%0d want 0 2", dat_rd_flag, blocks_left);
        end
        start(1'b0, 1'b1, 1'b1, 9, 0);
        tick();
        checks++;
        if (dat_wr_flag !== 1'b1 || dat_rd_flag !== 1'b0 || blocks_left !== 16'd2) begin
            errors++;
            $display("FAIL edge_busy_init got wr=%0b rd=%0b left=%0d want 1 0 2",
                     dat_wr_flag, dat_rd_flag, blocks_left);
        end
        #2;
        rst_L = 1'b0;
        #1;
        checks++;
        if ({dat_wr_flag, dat_rd_flag, busy, xfer_done, xfer_err, timeout_err} !== 6'b0 ||
            blocks_left !== '0) begin
            errors++;
            $display("FAIL edge_async_reset got flags=%b left=%0d want 0",
                     {dat_wr_flag, dat_rd_flag, busy, xfer_done, xfer_err, timeout_err}, blocks_left);
        end
        tick();
        rst_L = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_multi_read();
        test_open_ended();
        test_crc_error();
        test_timeout();
        test_edge_cases();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_pending got %0d outcomes outstanding want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
